// File: rtl/acc_serial_tx.sv
// acc_serial_tx: start/data/stop serial frame transmitter with a complementary line.
// Optional even parity bit: define ACC_SERIAL_TX_PARITY_EN.
module acc_serial_tx #(
    parameter int WIDTH        = 8,
    parameter int CLKS_PER_BIT = 4,
    parameter int CNT_W        = 8
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] din,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic             sout,
    output logic             sout_cmp
);

    localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] PER_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0]    BIT_LAST = BW'(WIDTH - 1);

`ifdef ACC_SERIAL_TX_PARITY_EN
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;
`else
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_DATA  = 3'd2,
        S_STOP  = 3'd4
    } state_t;
`endif

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   shreg_q, shreg_d;
    logic [WIDTH-1:0]   shreg_shift;
    logic [BW-1:0]      bit_q, bit_d;
    logic [CNT_W-1:0]   per_q, per_d;
    logic               sout_q, sout_d;
    logic               cmp_q;
    logic               done_q, done_d;
    logic               ready_q, ready_d;
    logic               busy_q, busy_d;
    logic               per_end;
`ifdef ACC_SERIAL_TX_PARITY_EN
    logic               par_q, par_d;
`endif

    assign per_end     = (per_q == PER_LAST);
    assign shreg_shift = shreg_q >> 1;

    // State and registered outputs; line and its complement share one edge.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state_q <= S_IDLE;
            shreg_q <= '0;
            bit_q   <= '0;
            per_q   <= '0;
            sout_q  <= 1'b1;
            cmp_q   <= 1'b0;
            done_q  <= 1'b0;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
`ifdef ACC_SERIAL_TX_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            bit_q   <= bit_d;
            per_q   <= per_d;
            sout_q  <= sout_d;
            cmp_q   <= ~sout_d;
            done_q  <= done_d;
            ready_q <= ready_d;
            busy_q  <= busy_d;
`ifdef ACC_SERIAL_TX_PARITY_EN
            par_q   <= par_d;
`endif
        end
    end

    // Next state, counters and next line value for each frame phase.
    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        bit_d   = bit_q;
        per_d   = per_q;
        sout_d  = sout_q;
        done_d  = 1'b0;
        ready_d = ready_q;
        busy_d  = busy_q;
`ifdef ACC_SERIAL_TX_PARITY_EN
        par_d   = par_q;
`endif
        case (state_q)
            S_IDLE: begin
                sout_d  = 1'b1;
                ready_d = 1'b1;
                busy_d  = 1'b0;
                if (load) begin
                    shreg_d = din;
`ifdef ACC_SERIAL_TX_PARITY_EN
                    par_d   = ^din;
`endif
                    state_d = S_START;
                    sout_d  = 1'b0;
                    per_d   = '0;
                    bit_d   = '0;
                    ready_d = 1'b0;
                    busy_d  = 1'b1;
                end
            end
            S_START: begin
                if (per_end) begin
                    per_d   = '0;
                    state_d = S_DATA;
                    sout_d  = shreg_q[0];
                end else begin
                    per_d = per_q + CNT_W'(1);
                end
            end
            S_DATA: begin
                if (per_end) begin
                    per_d = '0;
                    if (bit_q == BIT_LAST) begin
`ifdef ACC_SERIAL_TX_PARITY_EN
                        state_d = S_PARITY;
                        sout_d  = par_q;
`else
                        state_d = S_STOP;
                        sout_d  = 1'b1;
`endif
                    end else begin
                        shreg_d = shreg_shift;
                        bit_d   = bit_q + BW'(1);
                        sout_d  = shreg_shift[0];
                    end
                end else begin
                    per_d = per_q + CNT_W'(1);
                end
            end
`ifdef ACC_SERIAL_TX_PARITY_EN
            S_PARITY: begin
                if (per_end) begin
                    per_d   = '0;
                    state_d = S_STOP;
                    sout_d  = 1'b1;
                end else begin
                    per_d = per_q + CNT_W'(1);
                end
            end
`endif
            S_STOP: begin
                if (per_end) begin
                    per_d   = '0;
                    bit_d   = '0;
                    state_d = S_IDLE;
                    sout_d  = 1'b1;
                    done_d  = 1'b1;
                    ready_d = 1'b1;
                    busy_d  = 1'b0;
                end else begin
                    per_d = per_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
                sout_d  = 1'b1;
                per_d   = '0;
                bit_d   = '0;
                ready_d = 1'b1;
                busy_d  = 1'b0;
            end
        endcase
    end

    assign sout     = sout_q;
    assign sout_cmp = cmp_q;
    assign done     = done_q;
    assign ready    = ready_q;
    assign busy     = busy_q;

endmodule
